// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the multi-cycle ALU.
//   - opcode encoding for the 3-bit op field
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - bit positions of the {C,V,N,Z} flag vector
//   - small helper to classify the multi-cycle opcode
package alu_pkg;

   typedef logic [2:0] opcode_t;
   typedef logic [1:0] state_t;

   localparam opcode_t OpAdd  = 3'b000;
   localparam opcode_t OpSub  = 3'b001;
   localparam opcode_t OpAnd  = 3'b010;
   localparam opcode_t OpOr   = 3'b011;
   localparam opcode_t OpXor  = 3'b100;
   localparam opcode_t OpAdc  = 3'b101;
   localparam opcode_t OpMul  = 3'b110;
   localparam opcode_t OpPass = 3'b111;

   localparam state_t StIdle = 2'b00;
   localparam state_t StBusy = 2'b01;
   localparam state_t StDone = 2'b10;

   localparam int unsigned FlagC = 3;
   localparam int unsigned FlagV = 2;
   localparam int unsigned FlagN = 1;
   localparam int unsigned FlagZ = 0;

   // Only MUL takes the multi-cycle path; everything else completes on acceptance.
   function automatic logic is_mul(input opcode_t op);
      return op == OpMul;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned shift-add multiplier, one step per cycle.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         load operands a/b and begin WIDTH steps
//   a, b          multiplicand / multiplier (sampled only on start)
//   done          high in the cycle whose closing edge performs the last step
//   product       value the partial product takes at the closing edge of this
//                 cycle; equals the full 2*WIDTH-bit product while done=1
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   logic                 busy_q, busy_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   logic [2*WIDTH-1:0]   step_sum;
   logic                 last;

   // The last step and the result hand-off share one edge, so done is
   // combinational and product exposes the post-step value.
   assign last     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign step_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
   assign done     = last;
   assign product  = step_sum;

   always_comb begin
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      if (start) begin
         busy_d  = 1'b1;
         cnt_d   = '0;
         acc_d   = '0;
         mcand_d = {{WIDTH{1'b0}}, a};
         mplr_d  = b;
      end else if (busy_q) begin
         acc_d   = step_sum;
         mcand_d = mcand_q << 1;
         mplr_d  = mplr_q >> 1;
         cnt_d   = cnt_q + CNT_W'(1);
         if (last) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD SUB AND OR XOR ADC PASS) complete on acceptance;
// MUL runs WIDTH shift-add steps in alu_mul_seq before completing.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   in_valid / in_ready   operation handshake; a, b, op captured on acceptance
//   a, b, op              operands and opcode
//   out_valid / out_ready result handshake
//   result_lo, result_hi  low word / high product word (0 for non-MUL)
//   flags                 {C,V,N,Z} of the most recent completed operation
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result_lo,
   output logic [WIDTH-1:0]   result_hi,
   output logic [3:0]         flags
);

   localparam int unsigned Msb = WIDTH - 1;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     result_lo_q, result_lo_d;
   logic [WIDTH-1:0]     result_hi_q, result_hi_d;
   logic [3:0]           flags_q, flags_d;

   logic                 accept;
   logic                 mul_start;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_product;

   logic                 cin;
   logic [WIDTH:0]       sum_ext;
   logic [WIDTH:0]       diff_ext;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c;
   logic                 alu_v;
   logic [3:0]           alu_flags;
   logic [WIDTH-1:0]     mul_lo;
   logic [WIDTH-1:0]     mul_hi;
   logic [3:0]           mul_flags;

   // DONE with out_ready frees the slot in the same cycle, giving one op per cycle.
   assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == StDone);
   assign mul_start = accept && is_mul(op);

   alu_mul_seq #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle datapath. ADC takes its carry from the registered C flag.
   always_comb begin
      cin      = (op == OpAdc) ? flags_q[FlagC] : 1'b0;
      sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      diff_ext = {1'b0, a} - {1'b0, b};
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      unique case (op)
         OpAdd, OpAdc: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (a[Msb] == b[Msb]) && (alu_res[Msb] != a[Msb]);
         end
         OpSub: begin
            alu_res = diff_ext[WIDTH-1:0];
            alu_c   = diff_ext[WIDTH];  // borrow: a < b unsigned
            alu_v   = (a[Msb] != b[Msb]) && (alu_res[Msb] != a[Msb]);
         end
         OpAnd:  alu_res = a & b;
         OpOr:   alu_res = a | b;
         OpXor:  alu_res = a ^ b;
         OpPass: alu_res = a;
         OpMul:  alu_res = '0;          // handled by the multiplier
         default: alu_res = '0;
      endcase
      alu_flags        = '0;
      alu_flags[FlagC] = alu_c;
      alu_flags[FlagV] = alu_v;
      alu_flags[FlagN] = alu_res[Msb];
      alu_flags[FlagZ] = (alu_res == '0);
   end

   always_comb begin
      mul_lo           = mul_product[WIDTH-1:0];
      mul_hi           = mul_product[2*WIDTH-1:WIDTH];
      mul_flags        = '0;
      mul_flags[FlagC] = (mul_hi != '0);
      mul_flags[FlagN] = mul_lo[Msb];
      mul_flags[FlagZ] = (mul_lo == '0);
   end

   always_comb begin
      state_d     = state_q;
      result_lo_d = result_lo_q;
      result_hi_d = result_hi_q;
      flags_d     = flags_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               if (is_mul(op)) begin
                  state_d = StBusy;
               end else begin
                  state_d     = StDone;
                  result_lo_d = alu_res;
                  result_hi_d = '0;
                  flags_d     = alu_flags;
               end
            end else if (state_q == StDone && out_ready) begin
               state_d = StIdle;
            end
         end
         StBusy: begin
            if (mul_done) begin
               state_d     = StDone;
               result_lo_d = mul_lo;
               result_hi_d = mul_hi;
               flags_d     = mul_flags;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         result_lo_q <= '0;
         result_hi_q <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         result_lo_q <= result_lo_d;
         result_hi_q <= result_hi_d;
         flags_q     <= flags_d;
      end
   end

   assign result_lo = result_lo_q;
   assign result_hi = result_hi_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=8).
// Directed vector table, hand-written handshake/reset sequences, and random
// operations compared against an integer-arithmetic reference model.
module tb_alu_mc;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result_lo;
   logic [7:0] result_hi;
   logic [3:0] flags;

   int n_chk  = 0;
   int n_pass = 0;
   bit model_c = 1'b0;

   always #5 clk = ~clk;

   alu_mc #(
      .WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .flags     (flags)
   );

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] lo;
      logic [7:0] hi;
      logic [3:0] fl;
      int         lat;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] lo, input logic [7:0] hi,
                               input logic [3:0] fl, input int lat);
      vec_t v;
      v.op = o; v.a = x; v.b = y; v.lo = lo; v.hi = hi; v.fl = fl; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: plain integer arithmetic on the opcode's meaning.
   function automatic void model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input bit cin, output logic [7:0] lo, output logic [7:0] hi,
                                 output logic [3:0] fl);
      int ux, uy, sx, sy, full, sres;
      bit c, v;
      ux = int'(x); uy = int'(y);
      sx = (ux > 127) ? ux - 256 : ux;
      sy = (uy > 127) ? uy - 256 : uy;
      c = 1'b0; v = 1'b0; full = 0; sres = 0; hi = 8'h00;
      case (o)
         3'd0: begin full = ux + uy; c = (full > 255); sres = sx + sy;
                     v = (sres > 127) || (sres < -128); end
         3'd1: begin full = ux - uy; c = (ux < uy); sres = sx - sy;
                     v = (sres > 127) || (sres < -128); end
         3'd2: full = ux & uy;
         3'd3: full = ux | uy;
         3'd4: full = ux ^ uy;
         3'd5: begin full = ux + uy + int'(cin); c = (full > 255);
                     sres = sx + sy + int'(cin); v = (sres > 127) || (sres < -128); end
         3'd6: begin full = ux * uy; c = (full > 255); end
         default: full = ux;
      endcase
      lo = full[7:0];
      if (o == 3'd6) hi = full[15:8];
      fl = {c, v, lo[7], (lo == 8'h00)};
   endfunction

   // Issue one op from IDLE, wait for the result, optionally stall, then consume.
   task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input int stall, input string tag,
                         output logic [7:0] lo, output logic [7:0] hi, output logic [3:0] fl,
                         output int lat, output bit busy_ok, output bit hold_ok);
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
      chk({tag, " ready_at_issue"}, 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      // Scramble inputs after acceptance; they must be ignored.
      in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      lat = 1; busy_ok = 1'b1; hold_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (in_ready !== 1'b0) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      lo = result_lo; hi = result_hi; fl = flags;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || result_lo !== lo || result_hi !== hi || flags !== fl ||
             in_ready !== 1'b0) hold_ok = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic [7:0] lo, hi, elo, ehi;
   logic [3:0] fl, efl;
   logic [2:0] ro;
   logic [7:0] rx, ry;
   int         lat;
   bit         busy_ok, hold_ok;

   initial begin
      vecs[0]  = mk(3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1001, 1);
      vecs[1]  = mk(3'd5, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 1);
      vecs[2]  = mk(3'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0100, 1);
      vecs[3]  = mk(3'd1, 8'h01, 8'h02, 8'hFF, 8'h00, 4'b1010, 1);
      vecs[4]  = mk(3'd5, 8'h7F, 8'h00, 8'h80, 8'h00, 4'b0110, 1);
      vecs[5]  = mk(3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1);
      vecs[6]  = mk(3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001, 1);
      vecs[7]  = mk(3'd4, 8'hAA, 8'hFF, 8'h55, 8'h00, 4'b0000, 1);
      vecs[8]  = mk(3'd7, 8'h5A, 8'hFF, 8'h5A, 8'h00, 4'b0000, 1);
      vecs[9]  = mk(3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0110, 1);
      vecs[10] = mk(3'd6, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000, 9);
      vecs[11] = mk(3'd5, 8'h01, 8'h01, 8'h03, 8'h00, 4'b0000, 1);
      vecs[12] = mk(3'd6, 8'h10, 8'h10, 8'h00, 8'h01, 4'b1001, 9);
      vecs[13] = mk(3'd5, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 1);
      vecs[14] = mk(3'd6, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0001, 9);
      vecs[15] = mk(3'd0, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1101, 1);
      vecs[16] = mk(3'd2, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'b0010, 1);
      vecs[17] = mk(3'd5, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001, 1);

      // Reset state
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      #1;
      chk("reset in_ready", 32'(in_ready), 32'(1));
      chk("reset out_valid", 32'(out_valid), 32'(0));
      chk("reset flags", 32'(flags), 32'(0));
      chk("reset result_lo", 32'(result_lo), 32'(0));
      chk("reset result_hi", 32'(result_hi), 32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      // Directed table
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, i % 3, $sformatf("vec%0d", i),
                lo, hi, fl, lat, busy_ok, hold_ok);
         chk($sformatf("vec%0d result_lo", i), 32'(lo), 32'(vecs[i].lo));
         chk($sformatf("vec%0d result_hi", i), 32'(hi), 32'(vecs[i].hi));
         chk($sformatf("vec%0d flags", i), 32'(fl), 32'(vecs[i].fl));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("vec%0d busy_ready_low", i), 32'(busy_ok), 32'(1));
         chk($sformatf("vec%0d hold", i), 32'(hold_ok), 32'(1));
      end

      // Back-to-back ADD then ADC with out_ready held high
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h01;
      @(posedge clk); #1;
      chk("b2b add out_valid", 32'(out_valid), 32'(1));
      chk("b2b add result_lo", 32'(result_lo), 32'(8'h00));
      chk("b2b add flags", 32'(flags), 32'(4'b1001));
      op = 3'd5; a = 8'h00; b = 8'h00;
      chk("b2b in_ready in done", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b adc out_valid", 32'(out_valid), 32'(1));
      chk("b2b adc result_lo", 32'(result_lo), 32'(8'h01));
      chk("b2b adc flags", 32'(flags), 32'(4'b0000));
      @(posedge clk); #1;
      chk("b2b back to idle", 32'(out_valid), 32'(0));
      out_ready = 1'b0;

      // DONE held for 5 cycles with out_ready low
      @(negedge clk);
      in_valid = 1'b1; op = 3'd0; a = 8'h90; b = 8'h90;
      @(posedge clk); #1;
      op = 3'd7; a = 8'hC3; b = 8'h3C;  // keep offering; must not be accepted
      chk("stall out_valid", 32'(out_valid), 32'(1));
      for (int s = 0; s < 5; s++) begin
         @(posedge clk); #1;
         chk($sformatf("stall%0d result_lo", s), 32'(result_lo), 32'(8'h20));
         chk($sformatf("stall%0d flags", s), 32'(flags), 32'(4'b1100));
         chk($sformatf("stall%0d in_ready", s), 32'(in_ready), 32'(0));
         chk($sformatf("stall%0d out_valid", s), 32'(out_valid), 32'(1));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall release out_valid", 32'(out_valid), 32'(0));
      chk("stall release in_ready", 32'(in_ready), 32'(1));
      out_ready = 1'b0;

      // Reset in BUSY cycle 3 of a MUL
      @(negedge clk);
      in_valid = 1'b1; op = 3'd6; a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midmul in_ready busy", 32'(in_ready), 32'(0));
      rst = 1'b1;
      #1;
      chk("midmul rst out_valid", 32'(out_valid), 32'(0));
      chk("midmul rst flags", 32'(flags), 32'(0));
      chk("midmul rst result_lo", 32'(result_lo), 32'(0));
      chk("midmul rst result_hi", 32'(result_hi), 32'(0));
      chk("midmul rst in_ready", 32'(in_ready), 32'(1));
      in_valid = 1'b1; op = 3'd7; a = 8'h77;
      @(posedge clk); #1;
      chk("no accept in reset", 32'(out_valid), 32'(0));
      @(negedge clk); rst = 1'b0; in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("aborted mul discarded", 32'(out_valid), 32'(0));
      run_op(3'd7, 8'h5A, 8'h00, 0, "post_rst_pass", lo, hi, fl, lat, busy_ok, hold_ok);
      chk("post_rst pass result_lo", 32'(lo), 32'(8'h5A));
      chk("post_rst pass result_hi", 32'(hi), 32'(0));
      chk("post_rst pass flags", 32'(fl), 32'(4'b0000));
      chk("post_rst pass latency", 32'(lat), 32'(1));

      // Random operations against the reference model
      model_c = 1'b0;
      for (int i = 0; i < 150; i++) begin
         ro = 3'($urandom_range(0, 7));
         rx = 8'($urandom);
         ry = 8'($urandom);
         model(ro, rx, ry, model_c, elo, ehi, efl);
         run_op(ro, rx, ry, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i),
                lo, hi, fl, lat, busy_ok, hold_ok);
         chk($sformatf("rnd%0d op%0d result_lo", i, ro), 32'(lo), 32'(elo));
         chk($sformatf("rnd%0d op%0d result_hi", i, ro), 32'(hi), 32'(ehi));
         chk($sformatf("rnd%0d op%0d flags", i, ro), 32'(fl), 32'(efl));
         chk($sformatf("rnd%0d latency", i), 32'(lat), 32'((ro == 3'd6) ? 9 : 1));
         chk($sformatf("rnd%0d busy_ready_low", i), 32'(busy_ok), 32'(1));
         chk($sformatf("rnd%0d hold", i), 32'(hold_ok), 32'(1));
         model_c = efl[3];
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
